// File: rtl/dmem_pipe.sv
// dmem_pipe: word-addressed, byte-enabled data RAM behind valid/ready request and
// response channels with a LAT-stage read pipeline and stall back-pressure.
// Misaligned or out-of-range requests are answered with err=1, rdata=0 and never write.
// Define DMEM_PIPE_STATS_EN to add saturating 16-bit stat_rd/stat_wr/stat_err counters.
module dmem_pipe #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 32,
    parameter int unsigned LAT   = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [AW-1:0]   req_addr,
    input  logic [DW-1:0]   req_wdata,
    input  logic [DW/8-1:0] req_be,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_rdata,
    output logic            rsp_err
`ifdef DMEM_PIPE_STATS_EN
    ,
    output logic [15:0]     stat_rd,
    output logic [15:0]     stat_wr,
    output logic [15:0]     stat_err
`endif
);

    localparam int unsigned NB = DW / 8;
    localparam int unsigned OB = $clog2(NB);
    localparam int unsigned IW = $clog2(DEPTH);
    // First byte-address bit that lies above the RAM
    localparam int unsigned HB = OB + IW;

    logic [DW-1:0]          r_mem [DEPTH];
    logic [LAT-1:0]         r_vld;
    logic [LAT-1:0]         r_err;
    logic [LAT-1:0][DW-1:0] r_rdata;

    logic          w_stall;
    logic          w_accept;
    logic          w_misalign;
    logic          w_oor;
    logic          w_err;
    logic [IW-1:0] w_idx;
    logic [DW-1:0] w_rd_sample;

    assign w_idx = req_addr[HB-1:OB];

    if (OB > 0) begin : g_align
        assign w_misalign = |req_addr[OB-1:0];
    end else begin : g_no_align
        assign w_misalign = 1'b0;
    end

    if (HB < AW) begin : g_range
        assign w_oor = |req_addr[AW-1:HB];
    end else begin : g_no_range
        assign w_oor = 1'b0;
    end

    assign w_err     = w_misalign | w_oor;
    // The whole pipeline freezes while the head response waits for the consumer
    assign w_stall   = rsp_valid & ~rsp_ready;
    assign req_ready = ~w_stall;
    assign w_accept  = req_valid & req_ready;

    // Read data captured into stage 0: RAM word for good reads, zero otherwise
    always_comb begin
        w_rd_sample = '0;
        if (w_accept && !req_we && !w_err) begin
            w_rd_sample = r_mem[w_idx];
        end
    end

    // RAM byte-lane writes on the accept edge; contents are deliberately not reset
    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (w_accept && req_we && !w_err && req_be[b]) begin
                r_mem[w_idx][8*b +: 8] <= req_wdata[8*b +: 8];
            end
        end
    end

    // Response pipeline: load stage 0, shift the rest, hold everything on stall
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vld   <= '0;
            r_err   <= '0;
            r_rdata <= '0;
        end else if (!w_stall) begin
            r_vld[0]   <= w_accept;
            r_err[0]   <= w_accept & w_err;
            r_rdata[0] <= w_rd_sample;
            for (int i = 1; i < LAT; i++) begin
                r_vld[i]   <= r_vld[i-1];
                r_err[i]   <= r_err[i-1];
                r_rdata[i] <= r_rdata[i-1];
            end
        end
    end

    assign rsp_valid = r_vld[LAT-1];
    assign rsp_err   = r_err[LAT-1];
    assign rsp_rdata = r_rdata[LAT-1];

`ifdef DMEM_PIPE_STATS_EN
    logic [15:0] r_stat_rd;
    logic [15:0] r_stat_wr;
    logic [15:0] r_stat_err;

    // Saturating counters of accepted good reads, good writes and error requests
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stat_rd  <= '0;
            r_stat_wr  <= '0;
            r_stat_err <= '0;
        end else if (w_accept) begin
            if (w_err) begin
                if (r_stat_err != 16'hFFFF) r_stat_err <= r_stat_err + 16'd1;
            end else if (req_we) begin
                if (r_stat_wr != 16'hFFFF) r_stat_wr <= r_stat_wr + 16'd1;
            end else begin
                if (r_stat_rd != 16'hFFFF) r_stat_rd <= r_stat_rd + 16'd1;
            end
        end
    end

    assign stat_rd  = r_stat_rd;
    assign stat_wr  = r_stat_wr;
    assign stat_err = r_stat_err;
`endif

endmodule

// File: tb/tb_dmem_pipe.sv
// Directed self-checking bench for dmem_pipe (DW=32, DEPTH=64, LAT=2).
// Inputs are driven 1 ns after the rising edge; outputs are checked on the falling edge.
module tb_dmem_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
`ifdef DMEM_PIPE_STATS_EN
    logic [15:0] stat_rd;
    logic [15:0] stat_wr;
    logic [15:0] stat_err;
`endif

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    dmem_pipe #(
        .DW    (32),
        .DEPTH (64),
        .AW    (32),
        .LAT   (2)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
`ifdef DMEM_PIPE_STATS_EN
        ,
        .stat_rd   (stat_rd),
        .stat_wr   (stat_wr),
        .stat_err  (stat_err)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single isolated transaction: entered just after a rising edge with an empty pipe
    task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input logic [31:0] exp_rd, input logic exp_err);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        @(negedge clk);
        chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        step();
        req_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_early"}, {31'd0, rsp_valid}, 32'd0);
        step();
        @(negedge clk);
        chk({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
        chk({tag, "_rdata"}, rsp_rdata, exp_rd);
        chk({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        rsp_ready = 1'b1;
        #1 reset = 1'b0;
        #2;
        chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err", {31'd0, rsp_err}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        step();

        // Full write then read back
        xact("wr10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
        xact("rd10", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

        // Byte-enable merge
        xact("wr20a", 1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0, 1'b0);
        xact("wr20b", 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0);
        xact("rd20", 1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 1'b0);

        // Error cases and no-op writes leave RAM untouched
        xact("rd12", 1'b0, 32'h12, 32'h0, 4'h0, 32'h0, 1'b1);
        xact("rd100", 1'b0, 32'h100, 32'h0, 4'h0, 32'h0, 1'b1);
        xact("wr11", 1'b1, 32'h11, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
        xact("wr110", 1'b1, 32'h110, 32'h0, 4'hF, 32'h0, 1'b1);
        xact("wrbe0", 1'b1, 32'h10, 32'h0, 4'h0, 32'h0, 1'b0);
        xact("rd10b", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

        // Read accepted the cycle after a write to the same word sees new data
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30;
        req_wdata = 32'hCAFEF00D; req_be = 4'hF;
        step();
        req_we = 1'b0;
        step();
        req_valid = 1'b0;
        @(negedge clk);
        chk("raw_wrsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("raw_wrsp_rdata", rsp_rdata, 32'd0);
        step();
        @(negedge clk);
        chk("raw_rd_valid", {31'd0, rsp_valid}, 32'd1);
        chk("raw_rd_rdata", rsp_rdata, 32'hCAFEF00D);
        step();

        // Back-to-back reads with a 3-cycle consumer stall
        xact("pre0", 1'b1, 32'h0, 32'd1, 4'hF, 32'h0, 1'b0);
        xact("pre4", 1'b1, 32'h4, 32'd2, 4'hF, 32'h0, 1'b0);
        xact("pre8", 1'b1, 32'h8, 32'd3, 4'hF, 32'h0, 1'b0);
        xact("preC", 1'b1, 32'hC, 32'd4, 4'hF, 32'h0, 1'b0);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0;
        @(negedge clk);
        chk("b2b_ready0", {31'd0, req_ready}, 32'd1);
        step();
        req_addr = 32'h4;
        @(negedge clk);
        chk("b2b_c1_valid", {31'd0, rsp_valid}, 32'd0);
        chk("b2b_c1_ready", {31'd0, req_ready}, 32'd1);
        step();
        req_addr  = 32'h8;
        rsp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
            chk("stall_rdata", rsp_rdata, 32'd1);
            chk("stall_ready", {31'd0, req_ready}, 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("resume_rdata1", rsp_rdata, 32'd1);
        chk("resume_ready", {31'd0, req_ready}, 32'd1);
        step();
        req_addr = 32'hC;
        @(negedge clk);
        chk("resp2_valid", {31'd0, rsp_valid}, 32'd1);
        chk("resp2_rdata", rsp_rdata, 32'd2);
        step();
        req_valid = 1'b0;
        @(negedge clk);
        chk("resp3_valid", {31'd0, rsp_valid}, 32'd1);
        chk("resp3_rdata", rsp_rdata, 32'd3);
        step();
        @(negedge clk);
        chk("resp4_valid", {31'd0, rsp_valid}, 32'd1);
        chk("resp4_rdata", rsp_rdata, 32'd4);
        step();
        @(negedge clk);
        chk("drain1_valid", {31'd0, rsp_valid}, 32'd0);
        step();
        @(negedge clk);
        chk("drain2_valid", {31'd0, rsp_valid}, 32'd0);
        step();

        // Asynchronous reset with two reads in flight
        xact("wr40", 1'b1, 32'h40, 32'h55AA55AA, 4'hF, 32'h0, 1'b0);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h40;
        step();
        req_addr = 32'h10;
        step();
        req_valid = 1'b0;
        @(negedge clk);
        chk("inflight_valid", {31'd0, rsp_valid}, 32'd1);
        chk("inflight_rdata", rsp_rdata, 32'h55AA55AA);
        #2 reset = 1'b0;
        #1;
        chk("async_valid", {31'd0, rsp_valid}, 32'd0);
        chk("async_rdata", rsp_rdata, 32'd0);
        chk("async_err", {31'd0, rsp_err}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        step();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("post_rst_valid", {31'd0, rsp_valid}, 32'd0);
            chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
            step();
        end
        xact("rd40", 1'b0, 32'h40, 32'h0, 4'h0, 32'h55AA55AA, 1'b0);
        xact("rd20b", 1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 1'b0);
        xact("rd0", 1'b0, 32'h0, 32'h0, 4'h0, 32'd1, 1'b0);

`ifdef DMEM_PIPE_STATS_EN
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("stat_rd_clr", {16'd0, stat_rd}, 32'd0);
        chk("stat_wr_clr", {16'd0, stat_wr}, 32'd0);
        chk("stat_err_clr", {16'd0, stat_err}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        step();
        xact("s_rd10", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
        xact("s_rd20", 1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 1'b0);
        xact("s_rd40", 1'b0, 32'h40, 32'h0, 4'h0, 32'h55AA55AA, 1'b0);
        xact("s_wr50", 1'b1, 32'h50, 32'h12345678, 4'hF, 32'h0, 1'b0);
        xact("s_wr54", 1'b1, 32'h54, 32'h9ABCDEF0, 4'hF, 32'h0, 1'b0);
        xact("s_rd13", 1'b0, 32'h13, 32'h0, 4'h0, 32'h0, 1'b1);
        @(negedge clk);
        chk("stat_rd", {16'd0, stat_rd}, 32'd3);
        chk("stat_wr", {16'd0, stat_wr}, 32'd2);
        chk("stat_err", {16'd0, stat_err}, 32'd1);
        reset = 1'b0;
        #1;
        chk("stat_rd_rst", {16'd0, stat_rd}, 32'd0);
        chk("stat_wr_rst", {16'd0, stat_wr}, 32'd0);
        chk("stat_err_rst", {16'd0, stat_err}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_pipe.md
Name: dmem_pipe

Overview:
Parametrised successor to the single-cycle data memory. Provides a word-addressed, byte-enabled data RAM behind a valid/ready request channel and a valid/ready response channel, with a configurable read latency. Serves as the MEM-stage memory for the pipelined MIPS core, with stall back-pressure and error reporting for misaligned or out-of-range accesses.

Parameters:
DW, 32, data width in bits; must be a multiple of 8 and a power of two (>= 8)
DEPTH, 64, number of DW-bit words; power of two
AW, 32, byte-address width
LAT, 2, request-accept to response-valid latency in cycles; legal range 1..8

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  request can be accepted this cycle
req_we  input  1  1 = write, 0 = read
req_addr  input  AW  byte address
req_wdata  input  DW  write data
req_be  input  DW/8  byte enables for writes; ignored for reads
rsp_valid  output  1  response present
rsp_ready  input  1  consumer takes response this cycle
rsp_rdata  output  DW  read data; 0 for writes and for errors
rsp_err  output  1  access was misaligned or out of range

Behaviour:
- Definitions: OB = log2(DW/8). Word index = req_addr[OB+log2(DEPTH)-1:OB]. A request is accepted on a rising edge where req_valid && req_ready.
- Error rules: an access is misaligned when req_addr[OB-1:0] != 0. It is out of range when any bit of req_addr above OB+log2(DEPTH)-1 is set. An error request performs no write, returns rsp_rdata=0 and rsp_err=1, and consumes a pipeline slot like any other request.
- Writes: committed to RAM on the accept edge. Only the bytes whose req_be bit is set are written. A write with be=0 is a no-op but still produces a response (rdata=0, err=0).
- Reads: RAM is sampled on the accept edge, so a read accepted the cycle after a write to the same word returns the new data. The sampled data then travels through LAT pipeline stages, each holding valid, rdata and err.
- Latency: with no stall, a request accepted at edge k presents rsp_valid=1 during the cycle after edge k+LAT-1. For LAT=1, the response is valid the cycle after accept.
- Back-pressure: stall = rsp_valid && !rsp_ready. While stall is asserted, all stages hold and req_ready=0. Otherwise req_ready=1 and the stages advance every cycle. Bubbles are not compressed while stalled. Responses are never dropped or duplicated and are returned in acceptance order.
- Throughput: 1 request per cycle when rsp_ready is held high.
- Reset (reset=0, asynchronous): all stage valids are cleared, so rsp_valid=0, rsp_rdata=0, rsp_err=0, and req_ready=1 once reset deasserts. RAM contents are not reset. Any request in flight at reset is discarded with no response; a write accepted before reset stays committed.
- req_we, req_addr, req_wdata and req_be are don't-care when req_valid=0.

Optional Feature:
DMEM_PIPE_STATS_EN
- Defined: adds outputs stat_rd, stat_wr and stat_err, each 16 bits. They count accepted non-error reads, accepted non-error writes, and accepted error requests. Counters saturate at 16'hFFFF and are cleared by reset.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Test Plan:
- (DW=32, DEPTH=64, LAT=2) Write addr 0x10, wdata 0xDEADBEEF, be=4'hF; then read 0x10 -> rsp_valid 2 cycles after accept, rdata 0xDEADBEEF, err=0, write response rdata=0.
- Write 0x20 = 0x11223344 (be=F), then write 0x20 = 0xAABBCCDD with be=4'b0101, then read 0x20 -> rdata 0x11BB33DD.
- Read 0x12 (misaligned) and read 0x100 (out of range, index>63) -> both err=1, rdata=0; a follow-up read of 0x10 is unchanged.
- Issue 4 back-to-back reads (0x0, 0x4, 0x8, 0xC preloaded with 1..4) with rsp_ready=0 for 3 cycles starting when the first response appears -> req_ready=0 during the stall, responses 1,2,3,4 in order, no loss or duplication.
- Assert reset=0 mid-stream with 2 reads in flight -> rsp_valid falls immediately (asynchronously); after release, no stale responses; earlier writes are still readable.
- With DMEM_PIPE_STATS_EN: 3 good reads, 2 good writes, 1 misaligned access -> stat_rd=3, stat_wr=2, stat_err=1; reset clears all three to 0.
